// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc memory stage: rd source select, load funct3
// codes and the bus-transaction state enum.
package jzjpcc_pkg;

  typedef enum logic [1:0] {
    RD_ALU   = 2'b00,
    RD_MEM   = 2'b01,
    RD_RSVD2 = 2'b10,
    RD_RSVD3 = 2'b11
  } rd_source_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/jzjpcc_memory_if.sv
// Data-bus request/acknowledge interface between the memory stage and memory.
// Handshake: dReq is held with stable dAddr/dWriteData/dByteMask/dWrite until a
// cycle where dAck=1; that cycle completes the transfer (dReadData valid for
// loads). dAck while dReq=0 is ignored.
interface jzjpcc_memory_if;
  logic [29:0] dAddr;
  logic [31:0] dWriteData;
  logic [3:0]  dByteMask;
  logic        dWrite;
  logic        dReq;
  logic        dAck;
  logic [31:0] dReadData;

  modport master (
    output dAddr, dWriteData, dByteMask, dWrite, dReq,
    input  dAck, dReadData
  );

  modport slave (
    input  dAddr, dWriteData, dByteMask, dWrite, dReq,
    output dAck, dReadData
  );
endinterface

// File: rtl/jzjpcc_load_extractor.sv
// Combinational load alignment: selects the addressed byte/halfword lane of the
// read word and sign- or zero-extends it according to funct3.
module jzjpcc_load_extractor
  import jzjpcc_pkg::*;
(
  input  logic [31:0] dReadData,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] extended
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = dReadData[{offset, 3'b000} +: 8];
    // Halfword lane ignores offset bit 0 (misaligned halves are not split).
    halfLane = offset[1] ? dReadData[31:16] : dReadData[15:0];
    case (funct3)
      F3_LB:   extended = {{24{byteLane[7]}}, byteLane};
      F3_LBU:  extended = {24'h000000, byteLane};
      F3_LH:   extended = {{16{halfLane[15]}}, halfLane};
      F3_LHU:  extended = {16'h0000, halfLane};
      default: extended = dReadData;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory.sv
// jzjpcc memory stage: runs the data-bus transaction for loads/stores, stalls
// upstream while waiting, and registers the writeback result.
module jzjpcc_memory
  import jzjpcc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  input  logic [31:0]      aluResult,
  input  logic [31:0]      memDataToWrite,
  input  logic [3:0]       memByteMask,
  input  logic             memoryWriteEnable,
  input  rd_source_t       rdSource,
  input  logic [4:0]       rdAddr,
  input  logic             rdWriteEnable,
  input  logic [2:0]       funct3,
  jzjpcc_memory_if.master  dBus,
  output logic             stall,
  output logic             busError,
  output logic             wbValid,
  output logic [4:0]       wbRdAddr,
  output logic             wbRdWriteEnable,
  output logic [31:0]      wbRdData,
  output mem_state_t       debugState
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mem_state_t  state, stateNext;
  logic [CW-1:0] waitCount, waitCountNext;
  logic        memOp, isLoad, dReq, timedOut;
  logic [31:0] loadValue;

  assign memOp  = inValid & (memoryWriteEnable | (rdSource == RD_MEM));
  assign isLoad = ~memoryWriteEnable & (rdSource == RD_MEM);

  assign dBus.dAddr      = aluResult[31:2];
  assign dBus.dWriteData = memDataToWrite;
  assign dBus.dByteMask  = memoryWriteEnable ? memByteMask : 4'b1111;
  assign dBus.dWrite     = memoryWriteEnable;
  assign dBus.dReq       = dReq;
  assign debugState      = state;

  jzjpcc_load_extractor u_extract (
    .dReadData (dBus.dReadData),
    .funct3    (funct3),
    .offset    (aluResult[1:0]),
    .extended  (loadValue)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      waitCount <= '0;
    end else begin
      state     <= stateNext;
      waitCount <= waitCountNext;
    end
  end

  // waitCount counts cycles since the request was first raised, so the
  // abort lands TIMEOUT_CYCLES cycles after the initial IDLE request cycle.
  always_comb begin
    stateNext     = state;
    waitCountNext = '0;
    dReq          = 1'b0;
    stall         = 1'b0;
    timedOut      = 1'b0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          dReq = memOp;
          if (memOp && !dBus.dAck) begin
            stateNext     = ST_WAIT;
            stall         = 1'b1;
            waitCountNext = CW'(1);
          end
        end
        ST_WAIT: begin
          dReq = 1'b1;
          if (dBus.dAck) begin
            stateNext = ST_IDLE;
          end else if (TIMEOUT_CYCLES != 0 && waitCount == CW'(TIMEOUT_CYCLES)) begin
            stateNext = ST_IDLE;
            timedOut  = 1'b1;
          end else begin
            stall         = 1'b1;
            waitCountNext = waitCount + 1'b1;
          end
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busError        <= 1'b0;
      wbValid         <= 1'b0;
      wbRdWriteEnable <= 1'b0;
      wbRdAddr        <= '0;
      wbRdData        <= '0;
    end else begin
      if (timedOut) busError <= 1'b1;
      if (stall) begin
        wbValid         <= 1'b0;
        wbRdWriteEnable <= 1'b0;
      end else begin
        wbValid         <= inValid;
        wbRdWriteEnable <= inValid & rdWriteEnable;
        wbRdAddr        <= rdAddr;
        if (isLoad) wbRdData <= timedOut ? 32'h0 : loadValue;
        else        wbRdData <= aluResult;
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory.sv
// Self-checking bench for jzjpcc_memory: directed scenarios plus randomized
// instruction stream, writeback checked by a scoreboard monitor.
module tb_jzjpcc_memory;
  import jzjpcc_pkg::*;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic [31:0] aluResult, memDataToWrite;
  logic [3:0]  memByteMask;
  logic        memoryWriteEnable;
  rd_source_t  rdSource;
  logic [4:0]  rdAddr;
  logic        rdWriteEnable;
  logic [2:0]  funct3;
  logic        stall, busError, wbValid, wbRdWriteEnable;
  logic [4:0]  wbRdAddr;
  logic [31:0] wbRdData;
  mem_state_t  debugState;

  jzjpcc_memory_if dBus ();

  jzjpcc_memory #(.TIMEOUT_CYCLES(T)) dut (
    .clock             (clock),
    .reset             (reset),
    .inValid           (inValid),
    .aluResult         (aluResult),
    .memDataToWrite    (memDataToWrite),
    .memByteMask       (memByteMask),
    .memoryWriteEnable (memoryWriteEnable),
    .rdSource          (rdSource),
    .rdAddr            (rdAddr),
    .rdWriteEnable     (rdWriteEnable),
    .funct3            (funct3),
    .dBus              (dBus),
    .stall             (stall),
    .busError          (busError),
    .wbValid           (wbValid),
    .wbRdAddr          (wbRdAddr),
    .wbRdWriteEnable   (wbRdWriteEnable),
    .wbRdData          (wbRdData),
    .debugState        (debugState)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  logic [37:0] exp_q[$];   // {rdWriteEnable, rdAddr, data}
  logic expBusErr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference load semantics written with plain shifts and signed casts.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> (8 * int'(off)));
    h = 16'(word >> (16 * (int'(off) / 2)));
    case (f3)
      3'b000:  return int'($signed(b));
      3'b100:  return 32'(b);
      3'b001:  return int'($signed(h));
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        if (wbValid === 1'b1) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no writeback at %0t",
                     wbRdAddr, wbRdData, $time);
          end else begin
            check("wb", {26'd0, wbRdWriteEnable, wbRdAddr, wbRdData}, {26'd0, exp_q.pop_front()});
          end
        end else begin
          check("wb_bubble_we", {63'd0, wbRdWriteEnable}, 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inst(input logic v, input logic [31:0] alu, input logic [31:0] wdata,
                            input logic [3:0] mask, input logic weMem, input logic [1:0] src,
                            input logic [4:0] rd, input logic rdwe, input logic [2:0] f3);
    inValid           = v;
    aluResult         = alu;
    memDataToWrite    = wdata;
    memByteMask       = mask;
    memoryWriteEnable = weMem;
    rdSource          = rd_source_t'(src);
    rdAddr            = rd;
    rdWriteEnable     = rdwe;
    funct3            = f3;
  endtask

  // Runs the currently driven instruction to completion. ackDelay < 0: never ack.
  task automatic run_inst(input int ackDelay, input logic [31:0] word);
    logic memop, load, expStall, aborted, done;
    logic [31:0] data;
    int k;
    memop = inValid && (memoryWriteEnable || rdSource == RD_MEM);
    load  = !memoryWriteEnable && rdSource == RD_MEM;
    if (inValid) begin
      if (load) data = (ackDelay < 0) ? 32'h0 : model_load(word, funct3, aluResult[1:0]);
      else      data = aluResult;
      exp_q.push_back({rdWriteEnable, rdAddr, data});
    end
    if (!memop) begin
      dBus.dAck      = 1'($urandom_range(0, 1));
      dBus.dReadData = $urandom;
      @(negedge clock);
      check("idle_stall", {63'd0, stall}, 64'd0);
      check("idle_dreq", {63'd0, dBus.dReq}, 64'd0);
      check("busError", {63'd0, busError}, {63'd0, expBusErr});
      @(posedge clock); #1;
      dBus.dAck = 1'b0;
      return;
    end
    k = 0; done = 1'b0; aborted = 1'b0;
    while (!done) begin
      dBus.dAck      = (k == ackDelay);
      dBus.dReadData = (k == ackDelay) ? word : $urandom;
      @(negedge clock);
      expStall = !(k == ackDelay) && !(ackDelay < 0 && k == T);
      if (ackDelay < 0 && k == T) aborted = 1'b1;
      check("dreq", {63'd0, dBus.dReq}, 64'd1);
      check("daddr", {34'd0, dBus.dAddr}, {34'd0, aluResult[31:2]});
      check("dwrite", {63'd0, dBus.dWrite}, {63'd0, memoryWriteEnable});
      check("dmask", {60'd0, dBus.dByteMask}, {60'd0, memoryWriteEnable ? memByteMask : 4'hF});
      check("dwdata", {32'd0, dBus.dWriteData}, {32'd0, memDataToWrite});
      check("stall", {63'd0, stall}, {63'd0, expStall});
      check("busError", {63'd0, busError}, {63'd0, expBusErr});
      if (!expStall) done = 1'b1;
      @(posedge clock); #1;
      k++;
    end
    dBus.dAck = 1'b0;
    if (aborted) expBusErr = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    dBus.dAck = 1'b0;
    dBus.dReadData = 32'h0;
    drive_inst(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 2'b01, 5'd3, 1'b1, 3'b010);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_dreq", {63'd0, dBus.dReq}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_wbValid", {63'd0, wbValid}, 64'd0);
    check("rst_wbWe", {63'd0, wbRdWriteEnable}, 64'd0);
    check("rst_wbAddr", {59'd0, wbRdAddr}, 64'd0);
    check("rst_wbData", {32'd0, wbRdData}, 64'd0);
    check("rst_busError", {63'd0, busError}, 64'd0);
    check("rst_state", {63'd0, debugState}, {63'd0, ST_IDLE});
    @(posedge clock); #1;
    reset = 1'b1;

    // directed scenarios
    drive_inst(1'b1, 32'h1234, 32'h0, 4'h0, 1'b0, 2'b00, 5'd5, 1'b1, 3'b000);
    run_inst(0, 32'h0);
    drive_inst(1'b1, 32'h103, 32'h0, 4'h0, 1'b0, 2'b01, 5'd6, 1'b1, 3'b000);
    run_inst(0, 32'h80FF_0000);
    drive_inst(1'b1, 32'h103, 32'h0, 4'h0, 1'b0, 2'b01, 5'd7, 1'b1, 3'b100);
    run_inst(0, 32'h80FF_0000);
    drive_inst(1'b1, 32'h202, 32'h0, 4'h0, 1'b0, 2'b01, 5'd8, 1'b1, 3'b001);
    run_inst(3, 32'h8001_1234);
    drive_inst(1'b1, 32'h300, 32'h0000_ABCD, 4'b0011, 1'b1, 2'b00, 5'd0, 1'b0, 3'b010);
    run_inst(1, 32'h0);
    drive_inst(1'b1, 32'h404, 32'h0, 4'h0, 1'b0, 2'b01, 5'd9, 1'b1, 3'b010);
    run_inst(-1, 32'h0);
    drive_inst(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00, 5'd0, 1'b0, 3'b000);
    run_inst(0, 32'h0);

    // reset in the middle of a waiting load
    drive_inst(1'b1, 32'h508, 32'h0, 4'h0, 1'b0, 2'b01, 5'd10, 1'b1, 3'b010);
    dBus.dAck = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(negedge clock);
    check("midrst_dreq", {63'd0, dBus.dReq}, 64'd0);
    check("midrst_stall", {63'd0, stall}, 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("midrst_wbValid", {63'd0, wbValid}, 64'd0);
    check("midrst_busError", {63'd0, busError}, 64'd0);
    expBusErr = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    drive_inst(1'b0, 32'h508, 32'h0, 4'h0, 1'b0, 2'b01, 5'd10, 1'b1, 3'b010);
    repeat (3) run_inst(0, 32'h0);

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      int sel, dly;
      logic [1:0] src;
      logic weMem;
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        weMem = 1'b0;
        src = 2'($urandom_range(0, 2));
        if (src == 2'b01) src = 2'b11;
      end else if (sel == 1) begin
        weMem = 1'b0; src = 2'b01;
      end else begin
        weMem = 1'b1; src = 2'($urandom_range(0, 3));
      end
      drive_inst(($urandom_range(0, 9) != 0), $urandom, $urandom, 4'($urandom_range(0, 15)),
                 weMem, src, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      run_inst(dly, $urandom);
    end

    drive_inst(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 2'b00, 5'd0, 1'b0, 3'b000);
    repeat (2) run_inst(0, 32'h0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
